// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a time to a
// variable-latency instruction memory, and presents the fetched word to IF/ID.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        ImemReq,
   output logic [31:0] ImemAddr,
   input  logic        ImemReady,
   input  logic        ImemRespValid,
   input  logic [31:0] ImemRData,
   output logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic        InstrValidF,
   output logic        FetchBusyF
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      VALID = 3'd3,
      DROP  = 3'd4
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hold;
   logic [31:0] redirect_pc;
   logic        unused_tgt_lsb;

   assign redirect_pc    = {PCTargetE[31:2], 2'b00};
   assign unused_tgt_lsb = ^PCTargetE[1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pc    <= {RESET_PC[31:2], 2'b00};
         hold  <= '0;
      end else if (PCSrcE) begin
         // A redirect wins over stall and over a same-cycle response. If a request
         // is already in flight for the old PC, its response must be swallowed in DROP.
         pc <= redirect_pc;
         case (state)
            REQ:     state <= ImemReady     ? DROP : REQ;
            WAIT:    state <= ImemRespValid ? REQ  : DROP;
            DROP:    state <= ImemRespValid ? REQ  : DROP;
            default: state <= REQ;
         endcase
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ:  if (ImemReady) state <= WAIT;
            WAIT: if (ImemRespValid) begin
               hold  <= ImemRData;
               state <= VALID;
            end
            VALID: if (!StallF) begin
               pc    <= pc + 32'd4;
               state <= REQ;
            end
            DROP: if (ImemRespValid) state <= REQ;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs depend only on registered state, never on inputs.
   assign ImemReq     = (state == REQ);
   assign ImemAddr    = pc;
   assign PCF         = pc;
   assign PCPlus4F    = pc + 32'd4;
   assign InstrValidF = (state == VALID);
   assign InstrF      = InstrValidF ? hold : BUBBLE_INSTR;
   assign FetchBusyF  = ~InstrValidF;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit: a PC-stream model predicts each
// presented instruction; a memory model answers requests with random latency.
module tb_if_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] BUBBLE   = 32'h0000_0013;

   logic        clk, reset, StallF, PCSrcE, ImemReq, ImemReady, ImemRespValid;
   logic        InstrValidF, FetchBusyF;
   logic [31:0] PCTargetE, ImemAddr, ImemRData, InstrF, PCF, PCPlus4F;

   if_fetch_unit #(.RESET_PC(RESET_PC), .BUBBLE_INSTR(BUBBLE)) dut (
      .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady),
      .ImemRespValid(ImemRespValid), .ImemRData(ImemRData), .InstrF(InstrF), .PCF(PCF),
      .PCPlus4F(PCPlus4F), .InstrValidF(InstrValidF), .FetchBusyF(FetchBusyF)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int p_ready, p_stall, p_redir, max_lat;
   bit run_auto = 0, cadence_on = 0, seen = 0;
   int cyc = 0, last_pres = -1, idle_cyc = 0;
   logic [31:0] next_pc, redir_pc;
   logic [31:0] exp_q[$];
   logic [31:0] mq_addr[$];
   int          mq_cnt[$];

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset();
      chk("rst_req", 32'(ImemReq), 0);
      chk("rst_addr", ImemAddr, RESET_PC);
      chk("rst_instr", InstrF, BUBBLE);
      chk("rst_pcf", PCF, RESET_PC);
      chk("rst_pcplus4", PCPlus4F, RESET_PC + 32'd4);
      chk("rst_valid", 32'(InstrValidF), 0);
      chk("rst_busy", 32'(FetchBusyF), 1);
   endtask

   // Stimulus + memory model: decides inputs for the coming edge and predicts the PC stream.
   always @(negedge clk) begin
      logic        resp;
      logic [31:0] tgt;
      #1;
      if (run_auto) begin
         resp = 0;
         if (mq_addr.size() > 0) begin
            if (mq_cnt[0] == 0) resp = 1;
            else mq_cnt[0] = mq_cnt[0] - 1;
         end
         ImemRespValid = resp;
         ImemRData     = resp ? memfn(mq_addr[0]) : $urandom;
         ImemReady     = ($urandom_range(99) < p_ready);
         StallF        = ($urandom_range(99) < p_stall);
         PCSrcE        = ($urandom_range(99) < p_redir);
         case ($urandom_range(3))
            0:       tgt = $urandom;
            1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            default: tgt = 32'($urandom_range(32'h3FF));
         endcase
         PCTargetE = tgt;
         if (resp) begin
            void'(mq_addr.pop_front());
            void'(mq_cnt.pop_front());
         end
         if (ImemReq && ImemReady) begin
            mq_addr.push_back(ImemAddr);
            mq_cnt.push_back(int'($urandom_range(max_lat)));
         end
         if (PCSrcE) begin
            next_pc  = {tgt[31:2], 2'b00};
            redir_pc = next_pc;
            exp_q.delete();
            exp_q.push_back(next_pc);
         end else if (InstrValidF && !StallF) begin
            next_pc = next_pc + 32'd4;
            exp_q.push_back(next_pc);
         end
      end
   end

   // Monitor: pops the scoreboard on every new presentation and checks invariants.
   always @(negedge clk) begin
      logic [31:0] e;
      cyc++;
      idle_cyc++;
      if (!reset) begin
         if (PCSrcE) begin
            chk("redir_valid", 32'(InstrValidF), 0);
            chk("redir_pcf", PCF, redir_pc);
            seen = 0;
         end else if (seen && !StallF) begin
            seen = 0;
         end else if (seen && StallF) begin
            chk("stall_valid", 32'(InstrValidF), 1);
            chk("stall_noreq", 32'(ImemReq), 0);
         end
         chk("addr_eq_pcf", ImemAddr, PCF);
         chk("busy", 32'(FetchBusyF), 32'(!InstrValidF));
         if (!InstrValidF) chk("bubble", InstrF, BUBBLE);
         if (ImemReq) chk("one_outstanding", 32'(mq_addr.size()), 0);
         if (InstrValidF) idle_cyc = 0;
         if (InstrValidF && !seen) begin
            seen = 1;
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_instr: got pc %h, none expected", PCF);
            end else begin
               e = exp_q.pop_front();
               chk("pcf", PCF, e);
               chk("pcplus4", PCPlus4F, e + 32'd4);
               chk("instr", InstrF, memfn(e));
            end
            if (cadence_on && last_pres >= 0) chk("cadence", 32'(cyc - last_pres), 3);
            last_pres = cyc;
         end
         if (idle_cyc > 80) begin
            tests++; fails++;
            $display("FAIL progress: no instruction for %0d cycles, required <= 80", idle_cyc);
            idle_cyc = 0;
         end
      end
   end

   initial begin
      bit found;
      clk = 0; reset = 1; StallF = 0; PCSrcE = 0; PCTargetE = 0;
      ImemReady = 0; ImemRespValid = 0; ImemRData = 0;
      next_pc = RESET_PC; redir_pc = RESET_PC;
      exp_q.push_back(RESET_PC);
      #1 check_reset();

      // Ideal memory: one instruction every 3 cycles.
      p_ready = 100; p_stall = 0; p_redir = 0; max_lat = 0;
      @(negedge clk);
      run_auto = 1;
      #3 reset = 0;
      cadence_on = 1;
      repeat (16) @(negedge clk);
      #2 cadence_on = 0;

      p_ready = 70; p_stall = 30; p_redir = 8; max_lat = 3;
      repeat (2000) @(negedge clk);
      p_ready = 60; p_stall = 50; p_redir = 25; max_lat = 2;
      repeat (1000) @(negedge clk);

      // Reset while a request is outstanding, then a late response while IDLE.
      found = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!ImemReq && !InstrValidF && mq_addr.size() > 0) begin
            found = 1;
            break;
         end
      end
      run_auto = 0;
      if (!found) begin
         tests++; fails++;
         $display("FAIL find_wait: WAIT state not reached within 300 cycles");
      end
      PCSrcE = 0; StallF = 0; ImemRespValid = 0; ImemReady = 0;
      #2 reset = 1;
      mq_addr.delete(); mq_cnt.delete();
      exp_q.delete(); exp_q.push_back(RESET_PC);
      next_pc = RESET_PC; seen = 0;
      #1 check_reset();
      @(negedge clk);
      #1 reset = 0;
      ImemRespValid = 1; ImemRData = 32'hDEAD_BEEF;
      @(negedge clk);
      #1;
      chk("post_rst_req", 32'(ImemReq), 1);
      chk("post_rst_addr", ImemAddr, RESET_PC);
      chk("post_rst_valid", 32'(InstrValidF), 0);
      ImemRespValid = 0;
      #1 run_auto = 1;
      p_ready = 70; p_stall = 30; p_redir = 10; max_lat = 3;
      repeat (500) @(negedge clk);
      #2 run_auto = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Holds the PC and runs a single-outstanding valid/ready request to a variable-latency instruction memory.
- Presents InstrF/PCF/PCPlus4F plus InstrValidF to IF/ID.
- Applies EX-stage branch/jump redirects and squashes stale in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- BUBBLE_INSTR, 32'h0000_0000, value driven on InstrF when InstrValidF=0 (matches the IF/ID flush value).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- StallF  input  1  hazard unit holds fetch; IF/ID not accepting
- PCSrcE  input  1  redirect request from EX (taken branch/jump)
- PCTargetE  input  32  redirect target; bits [1:0] ignored, forced to 00
- ImemReq  output  1  request valid to instruction memory
- ImemAddr  output  32  request word address (byte address, [1:0]=00)
- ImemReady  input  1  memory accepts request this cycle
- ImemRespValid  input  1  read data valid; at least 1 cycle after acceptance
- ImemRData  input  32  instruction word
- InstrF  output  32  fetched instruction, or BUBBLE_INSTR
- PCF  output  32  PC of InstrF
- PCPlus4F  output  32  PCF + 4, modulo 2^32
- InstrValidF  output  1  InstrF holds a real instruction
- FetchBusyF  output  1  equals ~InstrValidF; hazard-unit visibility only

Behaviour:
- Reset (async, any state):
  - state=IDLE, PC=RESET_PC, hold register cleared.
  - Outputs: ImemReq=0, ImemAddr=RESET_PC, InstrF=BUBBLE_INSTR, PCF=RESET_PC, PCPlus4F=RESET_PC+4, InstrValidF=0, FetchBusyF=1.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- ImemAddr always equals PC. PCF always equals PC.
- States:
  - IDLE: first edge after reset release moves to REQ.
  - REQ: ImemReq=1. If ImemReady=1 at the edge, request is accepted and state moves to WAIT. Address may change while not accepted; memory samples it only on handshake.
  - WAIT: ImemReq=0. On ImemRespValid, ImemRData is captured into the hold register and state moves to VALID.
  - VALID: InstrValidF=1 and InstrF=hold register. If StallF=0 at the edge, IF/ID consumes the instruction, PC<=PC+4 and state moves to REQ. If StallF=1, everything holds.
  - DROP: waits for the response owed to a squashed request, discards the data, then moves to REQ.
- Redirect (PCSrcE=1 at an edge) has top priority over StallF and over a response arriving the same cycle. PC<={PCTargetE[31:2],2'b00} in every case. Next state:
  - IDLE: REQ.
  - REQ with ImemReady=0: REQ, next request uses the target.
  - REQ with ImemReady=1: DROP (the accepted request carried the old address).
  - WAIT without ImemRespValid: DROP.
  - WAIT with ImemRespValid: REQ, response discarded.
  - VALID: REQ, held instruction discarded, InstrValidF=0 next cycle.
  - DROP without ImemRespValid: DROP.
  - DROP with ImemRespValid: REQ.
- Throughput:
  - At most one outstanding request.
  - Best case is one instruction per 3 cycles (REQ, WAIT, VALID) with 1-cycle memory.
  - Latency from request acceptance to InstrValidF=1 is the memory latency + 1 cycle.
- PC wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- ImemRespValid in REQ, VALID or IDLE is a protocol violation: ignored, no state change.

Test Plan:
- Reset release, RESET_PC=0, memory ready and 1-cycle latency -> ImemAddr sequence 0x0,0x4,0x8. InstrValidF pulses with PCF=0x0,0x4,0x8 and PCPlus4F=0x4,0x8,0xC, each every 3rd cycle.
- StallF=1 for 4 cycles while VALID with InstrF=0x00500093 -> InstrF/PCF frozen, no ImemReq. Released -> next ImemAddr=PCF+4.
- PCSrcE=1, PCTargetE=0x0000_0103 while in WAIT, response 2 cycles later -> that response never appears on InstrF. Next ImemAddr=0x100, PCF=0x100.
- Redirect to 0x200 in the same cycle as ImemRespValid -> data discarded, state REQ, ImemAddr=0x200, InstrValidF stays 0.
- Redirect while VALID and StallF=1 -> InstrValidF=0 and InstrF=BUBBLE_INSTR the next cycle, ImemReq=1 to the target.
- Assert reset mid-WAIT and deassert -> all outputs at reset values, ImemAddr=RESET_PC. A late response arriving in IDLE is ignored.
